// File: rtl/shared_alu_arbiter_pkg.sv
// Shared types for the dual-core ALU arbiter: operand bundle, request and response records.
package shared_alu_arbiter_pkg;

  localparam int XLEN        = 32;
  localparam int ID_W        = 3;
  localparam int NUM_ALU_REQ = 2;

  typedef logic [ID_W-1:0] id_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_t;

  typedef struct packed {
    alu_op_t         op;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
  } alu_inputs_t;

  typedef struct packed {
    alu_inputs_t inputs;
    id_t         id;
  } alu_req_t;

  typedef struct packed {
    id_t             id;
    logic [XLEN-1:0] data;
  } alu_rsp_t;

endpackage

// File: rtl/shared_alu_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the core that did not win last time is chosen.
module rr_arbiter2 (
  input  logic [1:0] elig,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (elig == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = elig;
    end
  end

endmodule

// File: rtl/shared_alu_arbiter.sv
// Shares one combinational ALU between two cores: round-robin grant into a single
// execute stage, result captured into a per-core response register with valid/ack.
module shared_alu_arbiter
  import shared_alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_ALU_REQ
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic        [NUM_REQ-1:0]         req_valid,
  output logic        [NUM_REQ-1:0]         req_ready,
  input  alu_inputs_t [NUM_REQ-1:0]         req_inputs,
  input  id_t         [NUM_REQ-1:0]         req_id,
  input  logic        [NUM_REQ-1:0]         flush,
  output alu_inputs_t                       alu_inputs,
  output logic                              alu_valid,
  input  logic        [XLEN-1:0]            alu_result,
  output logic        [NUM_REQ-1:0]         rsp_valid,
  output id_t         [NUM_REQ-1:0]         rsp_id,
  output logic        [NUM_REQ-1:0][XLEN-1:0] rsp_data,
  input  logic        [NUM_REQ-1:0]         rsp_ack
);

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic               grant_idx;
  alu_req_t           grant_req;
  logic               capture;

  logic               last_grant_reg;
  logic               exec_valid_reg;
  logic               exec_owner_reg;
  alu_req_t           exec_req_reg;

  logic     [NUM_REQ-1:0] rsp_valid_reg;
  logic     [NUM_REQ-1:0] rsp_valid_next;
  alu_rsp_t [NUM_REQ-1:0] rsp_reg;
  alu_rsp_t [NUM_REQ-1:0] rsp_next;

  // A core may issue only when it has nothing in execute and its response slot
  // is empty or being drained this cycle; this keeps one op in flight per core.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
    assign elig[gi] = rst & req_valid[gi] & ~flush[gi]
                    & ~(exec_valid_reg & (exec_owner_reg == 1'(gi)))
                    & (~rsp_valid_reg[gi] | rsp_ack[gi]);
  end

  rr_arbiter2 u_rr_arbiter2 (
    .elig       (elig),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  assign req_ready        = grant;
  assign grant_idx        = grant[1];
  assign grant_req.inputs = req_inputs[grant_idx];
  assign grant_req.id     = req_id[grant_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_reg <= 1'b1;
      exec_valid_reg <= 1'b0;
      exec_owner_reg <= 1'b0;
      exec_req_reg   <= '0;
    end else begin
      exec_valid_reg <= |grant;
      if (|grant) begin
        exec_req_reg   <= grant_req;
        exec_owner_reg <= grant_idx;
        last_grant_reg <= grant_idx;
      end
    end
  end

  assign alu_inputs = exec_req_reg.inputs;
  assign alu_valid  = exec_valid_reg;

  // A flush of the owning core kills the op in execute before it can land.
  assign capture = exec_valid_reg & ~flush[exec_owner_reg];

  // Precedence per slot: flush, then capture (overrides a same-cycle ack), then ack.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
    logic cap_here;
    assign cap_here = capture & (exec_owner_reg == 1'(gi));

    always_comb begin
      rsp_valid_next[gi] = rsp_valid_reg[gi];
      rsp_next[gi]       = rsp_reg[gi];
      if (flush[gi]) begin
        rsp_valid_next[gi] = 1'b0;
      end else if (cap_here) begin
        rsp_valid_next[gi]  = 1'b1;
        rsp_next[gi].id     = exec_req_reg.id;
        rsp_next[gi].data   = alu_result;
      end else if (rsp_ack[gi]) begin
        rsp_valid_next[gi] = 1'b0;
      end
    end

    assign rsp_id[gi]   = rsp_reg[gi].id;
    assign rsp_data[gi] = rsp_reg[gi].data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_reg <= '0;
      rsp_reg       <= '0;
    end else begin
      rsp_valid_reg <= rsp_valid_next;
      rsp_reg       <= rsp_next;
    end
  end

  assign rsp_valid = rsp_valid_reg;

endmodule
